data_mem_mp: RTL and testbench

- Parametrised successor to the project's two-read-port data memory.
- Byte-addressed, word-organised RAM with one write port and NUM_RD read ports, byte/halfword/word write modes, and size-aware reads with sign/zero extension.
- Registered reads, a misalignment error flag, and a hardware clear engine that zeroes the array one word per cycle.
- Sits between the pipeline MEM stage and the display/IO readers.

---
 rtl/data_mem_pkg.sv | 41 ++++
 rtl/data_mem_mp_if.sv | 29 ++
 rtl/data_mem_clear_fsm.sv | 58 +++++
 rtl/data_mem_mp.sv | 151 +++++++++++++++
 tb/tb_data_mem_mp.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and the sub-word extract/extend helper for the multi-port data memory.
package data_mem_pkg;

  typedef enum logic [1:0] {
    MW_NONE = 2'b00,
    MW_HALF = 2'b01,
    MW_WORD = 2'b10,
    MW_BYTE = 2'b11
  } wr_mode_e;

  // Read size encodings; 00 is an alias for a full word.
  localparam logic [1:0] RS_WORD0 = 2'b00;
  localparam logic [1:0] RS_HALF  = 2'b01;
  localparam logic [1:0] RS_WORD  = 2'b10;
  localparam logic [1:0] RS_BYTE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CLEAR = 2'b01,
    DONE  = 2'b10
  } clr_state_e;

  // Pick the byte/halfword addressed by lane out of a 32-bit word and extend it.
  function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      RS_HALF: r = {{16{sgn & h[15]}}, h};
      RS_BYTE: r = {{24{sgn & b[7]}}, b};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_mp_if.sv
// Write/read/clear bus between the pipeline MEM stage (master) and the data memory (slave).
interface data_mem_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_RD = 2
);
  logic                       clear_req;
  logic                       busy;
  logic [1:0]                 wr_mode;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic                       wr_ready;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*2-1:0]        rd_size;
  logic [NUM_RD-1:0]          rd_signed;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic                       addr_err;

  modport master (
    output clear_req, wr_mode, wr_addr, wr_data, rd_addr, rd_size, rd_signed,
    input  busy, wr_ready, rd_data, rd_valid, addr_err
  );

  modport slave (
    input  clear_req, wr_mode, wr_addr, wr_data, rd_addr, rd_size, rd_signed,
    output busy, wr_ready, rd_data, rd_valid, addr_err
  );
endinterface

// File: rtl/data_mem_clear_fsm.sv
// Clear engine: walks every word index once, then reports DONE for one cycle.
module data_mem_clear_fsm
  import data_mem_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1,
  localparam int IDX_W         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_req_i,
  output logic             busy_o,
  output logic             clr_we_o,
  output logic [IDX_W-1:0] clr_idx_o,
  output logic             done_o
);

  clr_state_e       state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             busy_q;
  logic             pend_q;  // start request left over from reset release

  // State, counter and busy flag; busy spans CLEAR plus the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      pend_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (clear_req_i || pend_q) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == IDX_W'(DEPTH - 1)) state_q <= DONE;
          else                            cnt_q   <= cnt_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign clr_we_o  = (state_q == CLEAR);
  assign clr_idx_o = cnt_q;
  assign done_o    = (state_q == DONE);

endmodule

// File: rtl/data_mem_mp.sv
// Byte-addressed data memory: one write port, NUM_RD registered read ports, clear engine.
module data_mem_mp
  import data_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 256,
  parameter int ADDR_W         = 32,
  parameter int NUM_RD         = 2,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic          clk,
  input logic          rst_n,
  data_mem_mp_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic                            busy, clr_we, clr_done;
  logic [IDX_W-1:0]                clr_idx;
  logic [ADDR_W-1:0]               wa;
  wr_mode_e                        mode;
  logic                            wr_mis, wr_err, user_we;
  logic [NB-1:0]                   be, mem_be;
  logic [DATA_W-1:0]               wdat, mem_wdat;
  logic                            mem_we;
  logic [IDX_W-1:0]                mem_idx;
  logic [ADDR_W-1:0]               ra;
  logic [1:0]                      rs;
  logic                            rd_mis, rd_err;
  logic [DATA_W-1:0]               word;
  logic [31:0]                     sub;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data_d, rd_data_q;
  logic [NUM_RD-1:0]               rd_valid_d, rd_valid_q;
  logic                            addr_err_d, addr_err_q;

  function automatic logic addr_oor(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:IDX_W+2];
  endfunction

  data_mem_clear_fsm #(.DEPTH(DEPTH), .CLEAR_ON_RESET(CLEAR_ON_RESET)) u_clr (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req_i(bus.clear_req),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_idx_o  (clr_idx),
    .done_o     (clr_done)
  );

  // Decode the user write into byte enables and lane-aligned data; flag illegal writes.
  always_comb begin
    wa      = bus.wr_addr;
    mode    = wr_mode_e'(bus.wr_mode);
    wr_mis  = 1'b0;
    wr_err  = 1'b0;
    user_we = 1'b0;
    be      = '0;
    wdat    = '0;
    if (!busy && mode != MW_NONE) begin
      wr_mis = (mode == MW_HALF && wa[0]) || (mode == MW_WORD && wa[1:0] != 2'b00);
      if (wr_mis || addr_oor(wa)) wr_err  = 1'b1;
      else                        user_we = 1'b1;
    end
    for (int b = 0; b < NB; b++) begin
      case (mode)
        MW_WORD: begin
          be[b]          = 1'b1;
          wdat[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
        MW_HALF: begin
          be[b]          = (b < 4) && ((b / 2) == int'(wa[1]));
          wdat[8*b +: 8] = bus.wr_data[8*(b%2) +: 8];
        end
        MW_BYTE: begin
          be[b]          = (b == int'(wa[1:0]));
          wdat[8*b +: 8] = bus.wr_data[7:0];
        end
        default: ;
      endcase
    end
  end

  // Shared write port: the clear engine owns it while active.
  always_comb begin
    mem_we   = clr_we | user_we;
    mem_idx  = clr_we ? clr_idx : wa[IDX_W+1:2];
    mem_be   = clr_we ? '1 : be;
    mem_wdat = clr_we ? '0 : wdat;
  end

  // Array update; contents are deliberately untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  // Read-first lookup per port with size/sign handling and error detection.
  always_comb begin
    rd_err     = 1'b0;
    rd_mis     = 1'b0;
    ra         = '0;
    rs         = RS_WORD;
    word       = '0;
    sub        = '0;
    rd_data_d  = '0;
    rd_valid_d = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
      rs = bus.rd_size[2*i +: 2];
      if (!busy) begin
        rd_mis = (rs == RS_HALF && ra[0]) ||
                 ((rs == RS_WORD || rs == RS_WORD0) && ra[1:0] != 2'b00);
        if (rd_mis || addr_oor(ra)) begin
          rd_err = 1'b1;
        end else begin
          word          = mem_q[ra[IDX_W+1:2]];
          sub           = lane_extend(word[31:0], ra[1:0], rs, bus.rd_signed[i]);
          rd_data_d[i]  = (rs == RS_HALF || rs == RS_BYTE) ? DATA_W'($signed(sub)) : word;
          rd_valid_d[i] = 1'b1;
        end
      end
    end
    addr_err_d = clr_done ? 1'b0 : (addr_err_q | wr_err | rd_err);
  end

  // Registered read outputs and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.wr_ready = !busy;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_data_mem_mp.sv
// Self-checking bench for data_mem_mp against a byte-array reference model.
module tb_data_mem_mp;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 32;
  localparam int NUM_RD = 2;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  data_mem_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

  data_mem_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
                .CLEAR_ON_RESET(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  logic [7:0] mb [DEPTH*4];
  int         left;    // busy cycles still to come
  bit         pend;    // clear pending from reset release
  bit         undef;   // array contents unknown (before the first clear)
  logic       err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int sz_bytes_rd(input logic [1:0] sz);
    return (sz == 2'b01) ? 2 : (sz == 2'b11) ? 1 : 4;
  endfunction

  function automatic void model_read(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                     output logic [31:0] d, output logic v, output logic e);
    int n;
    n = sz_bytes_rd(sz);
    d = 0; v = 0; e = 0;
    if (a >= DEPTH*4 || (a % n) != 0) begin
      e = 1;
      return;
    end
    v = 1;
    for (int k = 0; k < n; k++) d = d | (32'(mb[a+k]) << (8*k));
    if (sg && n < 4 && d[8*n-1]) d = d | ~((32'd1 << (8*n)) - 1);
  endfunction

  function automatic void model_write(input logic [1:0] md, input logic [31:0] a,
                                      input logic [31:0] wd, output logic e);
    int n;
    e = 0;
    if (md == 2'b00) return;
    n = (md == 2'b01) ? 2 : (md == 2'b10) ? 4 : 1;
    if (a >= DEPTH*4 || (a % n) != 0) begin
      e = 1;
      return;
    end
    for (int k = 0; k < n; k++) mb[a+k] = wd[8*k +: 8];
  endfunction

  task automatic idle();
    bus.clear_req = 0;
    bus.wr_mode   = 2'b00;
    bus.wr_addr   = 0;
    bus.wr_data   = 0;
    bus.rd_addr   = 0;
    bus.rd_size   = 0;
    bus.rd_signed = 0;
  endtask

  task automatic set_rd(input int p, input logic [31:0] a, input logic [1:0] sz, input logic sg);
    bus.rd_addr[p*ADDR_W +: ADDR_W] = a;
    bus.rd_size[2*p +: 2]           = sz;
    bus.rd_signed[p]                = sg;
  endtask

  task automatic set_wr(input logic [1:0] md, input logic [31:0] a, input logic [31:0] wd);
    bus.wr_mode = md;
    bus.wr_addr = a;
    bus.wr_data = wd;
  endtask

  // One clock: predict, advance, compare every output.
  task automatic cycle();
    logic [31:0] ed [NUM_RD];
    logic        ev [NUM_RD];
    logic        e, any_err;
    bit          start;
    any_err = 0;
    start   = 0;
    for (int p = 0; p < NUM_RD; p++) begin
      ed[p] = 0;
      ev[p] = 0;
    end
    if (left == 0) begin
      for (int p = 0; p < NUM_RD; p++) begin
        model_read(bus.rd_addr[p*ADDR_W +: ADDR_W], bus.rd_size[2*p +: 2], bus.rd_signed[p],
                   ed[p], ev[p], e);
        any_err = any_err | e;
      end
      model_write(bus.wr_mode, bus.wr_addr, bus.wr_data, e);
      any_err = any_err | e;
      start = bus.clear_req || pend;
      if (any_err) err_m = 1;
      if (start) begin
        left  = DEPTH + 1;
        undef = 0;
        for (int k = 0; k < DEPTH*4; k++) mb[k] = 8'h00;
      end
    end else begin
      left--;
      if (left == 0) err_m = 0;
    end
    pend = 0;
    @(posedge clk);
    #1;
    chk("busy", 32'(bus.busy), 32'(left > 0));
    chk("wr_ready", 32'(bus.wr_ready), 32'(left == 0));
    chk("addr_err", 32'(bus.addr_err), 32'(err_m));
    for (int p = 0; p < NUM_RD; p++) begin
      chk($sformatf("rd_valid%0d", p), 32'(bus.rd_valid[p]), 32'(ev[p]));
      if (!(undef && ev[p])) chk($sformatf("rd_data%0d", p), bus.rd_data[p*DATA_W +: DATA_W], ed[p]);
    end
  endtask

  task automatic model_reset();
    left  = 0;
    pend  = 1;
    undef = 1;
    err_m = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'd0);
    chk({tag, "_addr_err"}, 32'(bus.addr_err), 32'd0);
    chk({tag, "_rd_data0"}, bus.rd_data[31:0], 32'd0);
    chk({tag, "_rd_data1"}, bus.rd_data[63:32], 32'd0);
  endtask

  // Run until busy drops, returning the number of busy cycles observed.
  task automatic wait_clear(output int cnt);
    bit fin;
    cnt = 0;
    fin = 0;
    for (int k = 0; k < 400 && !fin; k++) begin
      cycle();
      if (bus.busy) cnt++;
      else if (cnt > 0) fin = 1;
    end
  endtask

  initial begin
    int cnt;
    logic [31:0] a;
    logic [1:0]  md, sz;
    vectors     = 0;
    miscompares = 0;
    idle();
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Auto-clear after reset release lasts DEPTH+1 cycles
    wait_clear(cnt);
    chk("auto_clear_len", 32'(cnt), 32'(DEPTH + 1));
    set_rd(0, 32'h0, 2'b10, 0);
    set_rd(1, 32'h3FC, 2'b10, 0);
    cycle();
    chk("clr_rd0", bus.rd_data[31:0], 32'h0);
    chk("clr_rd1", bus.rd_data[63:32], 32'h0);
    chk("clr_vld", 32'(bus.rd_valid), 32'h3);

    // Word write then byte write into lane 1 of the next word
    idle();
    set_wr(2'b10, 32'h0, 32'h12345678);
    cycle();
    set_wr(2'b11, 32'h5, 32'h00000058);
    cycle();
    idle();
    set_rd(0, 32'h4, 2'b10, 0);
    set_rd(1, 32'h3, 2'b11, 0);
    cycle();
    chk("byte_lane_word4", bus.rd_data[31:0], 32'h00005800);
    chk("byte_rd3", bus.rd_data[63:32], 32'h00000012);

    // Halfword write, signed and unsigned halfword reads
    idle();
    set_wr(2'b01, 32'h6, 32'h000080FF);
    cycle();
    idle();
    set_rd(0, 32'h6, 2'b01, 1);
    set_rd(1, 32'h6, 2'b01, 0);
    cycle();
    chk("half_signed", bus.rd_data[31:0], 32'hFFFF80FF);
    chk("half_unsigned", bus.rd_data[63:32], 32'h000080FF);

    // Read-first on a same-cycle write
    idle();
    set_wr(2'b10, 32'h8, 32'hAAAA5555);
    set_rd(0, 32'h8, 2'b10, 0);
    cycle();
    chk("rdfirst_old", bus.rd_data[31:0], 32'h0);
    bus.wr_mode = 2'b00;
    cycle();
    chk("rdfirst_new", bus.rd_data[31:0], 32'hAAAA5555);

    // Misaligned write plus out-of-range read
    idle();
    set_wr(2'b10, 32'h2, 32'hDEADBEEF);
    set_rd(0, 32'h1000, 2'b10, 0);
    set_rd(1, 32'h0, 2'b10, 0);
    cycle();
    chk("oor_valid", 32'(bus.rd_valid[0]), 32'd0);
    chk("err_set", 32'(bus.addr_err), 32'd1);
    bus.wr_mode = 2'b00;
    cycle();
    chk("mis_wr_suppressed", bus.rd_data[63:32], 32'h12345678);
    idle();
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    wait_clear(cnt);
    chk("err_cleared", 32'(bus.addr_err), 32'd0);

    // Write during busy is dropped; reset mid-clear restarts the clear
    bus.clear_req = 1;
    cycle();
    bus.clear_req = 0;
    set_wr(2'b10, 32'h10, 32'h00000055);
    cycle();
    chk("busy_wr_ready", 32'(bus.wr_ready), 32'd0);
    for (int k = 0; k < 20; k++) cycle();
    idle();
    rst_n = 1'b0;
    #1 check_reset_outputs("midclr");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_clear(cnt);
    chk("restart_clear_len", 32'(cnt), 32'(DEPTH + 1));
    set_rd(0, 32'h10, 2'b10, 0);
    cycle();
    chk("dropped_wr", bus.rd_data[31:0], 32'h0);

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      idle();
      md = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, DEPTH*4 - 1));
      if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
      if ($urandom_range(0, 15) == 0) a = a | 32'h1000;
      set_wr(md, a, $urandom);
      for (int p = 0; p < NUM_RD; p++) begin
        sz = 2'($urandom_range(0, 3));
        a  = 32'($urandom_range(0, DEPTH*4 - 1));
        if ($urandom_range(0, 1) == 0) a = a & ~32'h3;
        if ($urandom_range(0, 31) == 0) a = a | 32'h2000;
        set_rd(p, a, sz, 1'($urandom_range(0, 1)));
      end
      bus.clear_req = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
